// File: rtl/wb_burst_master_if.sv
// Wishbone B4 pipelined bus bundle between wb_burst_master and its slave.
// datW/adr/sel/cyc/stb/we/lock flow master->slave; datR/ack/stall/err/rty flow back.
interface wb_burst_master_if #(
    parameter int WB_BUS_WIDTH  = 16,
    parameter int WB_ADDR_WIDTH = 32
) ();
    logic [WB_BUS_WIDTH-1:0]   datW;
    logic [WB_BUS_WIDTH-1:0]   datR;
    logic [WB_ADDR_WIDTH-1:0]  adr;
    logic [WB_BUS_WIDTH/8-1:0] sel;
    logic                      cyc;
    logic                      stb;
    logic                      we;
    logic                      lock;
    logic                      ack;
    logic                      stall;
    logic                      err;
    logic                      rty;

    modport master (
        output datW, adr, sel, cyc, stb, we, lock,
        input  datR, ack, stall, err, rty
    );

    modport slave (
        input  datW, adr, sel, cyc, stb, we, lock,
        output datR, ack, stall, err, rty
    );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B4 pipelined burst master: one valid/ready burst request, back-to-back beats, rty restart, err abort.
// Optional ack timeout is compiled in when WB_MASTER_TIMEOUT_EN is defined.
module wb_burst_master #(
    parameter int WB_BUS_WIDTH   = 16,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int MAX_BURST      = 8,
`ifdef WB_MASTER_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 255,
`endif
    parameter int RETRY_LIMIT    = 3
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_reset_n_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic                         req_we_i,
    input  logic [WB_ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [$clog2(MAX_BURST)-1:0] req_len_i,
    input  logic [WB_BUS_WIDTH-1:0]      wr_data_i,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    output logic [WB_BUS_WIDTH-1:0]      rd_data_o,
    output logic                         rd_valid_o,
    output logic                         done_o,
    output logic                         err_o,
    wb_burst_master_if.master            wb
);
    localparam int LEN_W = $clog2(MAX_BURST);
    localparam int SEL_W = WB_BUS_WIDTH / 8;
    localparam int CNT_W = LEN_W + 1;
    localparam int RTY_W = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RETRY = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WB_ADDR_WIDTH-1:0] startAddr_q, startAddr_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic                     we_q, we_d;
    logic [CNT_W-1:0]         issuedCnt_q, issuedCnt_d;
    logic [CNT_W-1:0]         ackedCnt_q, ackedCnt_d;
    logic [RTY_W-1:0]         retryCnt_q, retryCnt_d;
    logic [WB_BUS_WIDTH-1:0]  rdData_q, rdData_d;
    logic                     rdValid_q, rdValid_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     ready_q, ready_d;

    logic             cyc, stb, issue, ackV, errV, rtyV, failTmo;
    logic [CNT_W-1:0] beats, issuedInc, ackedInc;

    assign cyc       = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign stb       = (state_q == S_ISSUE) && (!we_q || wr_valid_i);
    assign issue     = stb && !wb.stall;
    assign ackV      = cyc && wb.ack;
    assign errV      = cyc && wb.err;
    assign rtyV      = cyc && wb.rty;
    assign beats     = {1'b0, len_q} + CNT_W'(1);
    assign issuedInc = issuedCnt_q + CNT_W'(issue);
    assign ackedInc  = ackedCnt_q + CNT_W'(ackV);

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmoCnt_q, tmoCnt_d;

    // Idle bus cycles only count while acks are owed; any issue or ack restarts the window.
    always_comb begin
        tmoCnt_d = '0;
        failTmo  = 1'b0;
        if (cyc && !issue && !ackV && ((issuedCnt_q != ackedCnt_q) || (state_q == S_WAIT))) begin
            tmoCnt_d = tmoCnt_q + TMO_W'(1);
            failTmo  = (tmoCnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) tmoCnt_q <= '0;
        else               tmoCnt_q <= tmoCnt_d;
    end
`else
    assign failTmo = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        startAddr_d = startAddr_q;
        len_d       = len_q;
        we_d        = we_q;
        issuedCnt_d = issuedCnt_q;
        ackedCnt_d  = ackedCnt_q;
        retryCnt_d  = retryCnt_q;
        rdData_d    = rdData_q;
        rdValid_d   = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i && ready_q) begin
                    state_d     = S_ISSUE;
                    addr_d      = req_addr_i;
                    startAddr_d = req_addr_i;
                    len_d       = req_len_i;
                    we_d        = req_we_i;
                    issuedCnt_d = '0;
                    ackedCnt_d  = '0;
                    retryCnt_d  = '0;
                end
            end
            S_ISSUE, S_WAIT: begin
                // err outranks rty, which outranks ack; a losing ack is dropped.
                if (errV || (rtyV && (we_q || retryCnt_q == RTY_W'(RETRY_LIMIT)))) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (rtyV) begin
                    state_d    = S_RETRY;
                    retryCnt_d = retryCnt_q + RTY_W'(1);
                end else begin
                    if (issue) begin
                        addr_d      = addr_q + WB_ADDR_WIDTH'(SEL_W);
                        issuedCnt_d = issuedInc;
                    end
                    ackedCnt_d = ackedInc;
                    if (ackV && !we_q) begin
                        rdValid_d = 1'b1;
                        rdData_d  = wb.datR;
                    end
                    if (ackV && (ackedInc == beats)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (failTmo) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (issue && (issuedInc == beats)) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_RETRY: begin
                state_d     = S_ISSUE;
                addr_d      = startAddr_q;
                issuedCnt_d = '0;
                ackedCnt_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ready_q mirrors "next state is IDLE" so req_ready_o stays low until the first clock after reset.
    assign ready_d = (state_d == S_IDLE);

    always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            startAddr_q <= '0;
            len_q       <= '0;
            we_q        <= 1'b0;
            issuedCnt_q <= '0;
            ackedCnt_q  <= '0;
            retryCnt_q  <= '0;
            rdData_q    <= '0;
            rdValid_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            startAddr_q <= startAddr_d;
            len_q       <= len_d;
            we_q        <= we_d;
            issuedCnt_q <= issuedCnt_d;
            ackedCnt_q  <= ackedCnt_d;
            retryCnt_q  <= retryCnt_d;
            rdData_q    <= rdData_d;
            rdValid_q   <= rdValid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
        end
    end

    // Write data passes straight through; upstream holds it while wr_ready_o is low.
    assign wb.cyc      = cyc;
    assign wb.stb      = stb;
    assign wb.adr      = addr_q;
    assign wb.datW     = (stb && we_q) ? wr_data_i : '0;
    assign wb.sel      = {SEL_W{cyc}};
    assign wb.we       = cyc && we_q;
    assign wb.lock     = cyc && (len_q != '0);
    assign wr_ready_o  = we_q && issue;
    assign req_ready_o = ready_q;
    assign rd_data_o   = rdData_q;
    assign rd_valid_o  = rdValid_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master (default build): cycle vector table plus directed retry/err/reset sequences.
module tb_wb_burst_master;
    logic        clk = 1'b0;
    logic        rstN;
    logic        reqValid, reqReady, reqWe;
    logic [31:0] reqAddr;
    logic [2:0]  reqLen;
    logic [15:0] wrData, rdData;
    logic        wrValid, wrReady, rdValid, done, errO;

    int assertions = 0;
    int failures   = 0;

    wb_burst_master_if #(.WB_BUS_WIDTH(16), .WB_ADDR_WIDTH(32)) wbIf ();

    wb_burst_master #(
        .WB_BUS_WIDTH(16), .WB_ADDR_WIDTH(32), .MAX_BURST(8), .RETRY_LIMIT(3)
    ) dut (
        .wb_clk_i(clk), .wb_reset_n_i(rstN),
        .req_valid_i(reqValid), .req_ready_o(reqReady), .req_we_i(reqWe),
        .req_addr_i(reqAddr), .req_len_i(reqLen),
        .wr_data_i(wrData), .wr_valid_i(wrValid), .wr_ready_o(wrReady),
        .rd_data_o(rdData), .rd_valid_o(rdValid),
        .done_o(done), .err_o(errO),
        .wb(wbIf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        reqValid, reqWe;
        logic [31:0] reqAddr;
        logic [2:0]  reqLen;
        logic        wrValid;
        logic [15:0] wrData;
        logic        ack, stall;
        logic [15:0] datR;
        logic        expReady, expCyc, expStb, expWe, expLock;
        logic [31:0] expAdr;
        logic [15:0] expDatW;
        logic        expWrReady, expRdValid;
        logic [15:0] expRdData;
        logic        expDone, expErr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t V(
        input logic rv, input logic we, input logic [31:0] addr, input logic [2:0] len,
        input logic wv, input logic [15:0] wd, input logic ack, input logic stall, input logic [15:0] dr,
        input logic eReady, input logic eCyc, input logic eStb, input logic eWe, input logic eLock,
        input logic [31:0] eAdr, input logic [15:0] eDat, input logic eWrRdy, input logic eRdV,
        input logic [15:0] eRdD, input logic eDone, input logic eErr);
        vec_t v;
        v.reqValid = rv;  v.reqWe = we;  v.reqAddr = addr;  v.reqLen = len;
        v.wrValid = wv;   v.wrData = wd; v.ack = ack;       v.stall = stall;  v.datR = dr;
        v.expReady = eReady; v.expCyc = eCyc; v.expStb = eStb; v.expWe = eWe; v.expLock = eLock;
        v.expAdr = eAdr;  v.expDatW = eDat; v.expWrReady = eWrRdy; v.expRdValid = eRdV;
        v.expRdData = eRdD; v.expDone = eDone; v.expErr = eErr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        checkOutput(name, 32'(act), 32'(exp));
    endtask

    task automatic setBus(input logic ack, input logic stall, input logic err, input logic rty,
                          input logic [15:0] dr);
        wbIf.ack = ack; wbIf.stall = stall; wbIf.err = err; wbIf.rty = rty; wbIf.datR = dr;
    endtask

    task automatic clearInputs();
        reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqLen = '0;
        wrValid = 1'b0; wrData = '0;
        setBus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic applyStimulus(input vec_t v);
        reqValid = v.reqValid; reqWe = v.reqWe; reqAddr = v.reqAddr; reqLen = v.reqLen;
        wrValid = v.wrValid; wrData = v.wrData;
        setBus(v.ack, v.stall, 1'b0, 1'b0, v.datR);
    endtask

    task automatic checkRow(input vec_t v, input int i);
        checkFlag($sformatf("row%0d req_ready", i), reqReady, v.expReady);
        checkFlag($sformatf("row%0d cyc", i), wbIf.cyc, v.expCyc);
        checkFlag($sformatf("row%0d stb", i), wbIf.stb, v.expStb);
        checkFlag($sformatf("row%0d we", i), wbIf.we, v.expWe);
        checkFlag($sformatf("row%0d lock", i), wbIf.lock, v.expLock);
        checkOutput($sformatf("row%0d sel", i), 32'(wbIf.sel), 32'({2{v.expCyc}}));
        checkFlag($sformatf("row%0d wr_ready", i), wrReady, v.expWrReady);
        checkFlag($sformatf("row%0d rd_valid", i), rdValid, v.expRdValid);
        checkFlag($sformatf("row%0d done", i), done, v.expDone);
        if (v.expStb) checkOutput($sformatf("row%0d adr", i), wbIf.adr, v.expAdr);
        if (v.expStb && v.expWe) checkOutput($sformatf("row%0d dat_o", i), 32'(wbIf.datW), 32'(v.expDatW));
        if (v.expRdValid) checkOutput($sformatf("row%0d rd_data", i), 32'(rdData), 32'(v.expRdData));
        if (v.expDone) checkFlag($sformatf("row%0d err", i), errO, v.expErr);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Global guard so a broken DUT can never hang the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int attempts;
        logic prevCyc, seen, errSeen;

        // Read len=3 @0x100, ack one cycle after each issue.
        vecs.push_back(V(1'b1,1'b0,32'h100,3'd3, 1'b0,16'h0, 1'b0,1'b0,16'h0,    1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,16'h0,   1'b0,1'b0,16'h0,    1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b0,16'h0, 1'b0,1'b0,16'h0,    1'b0,1'b1,1'b1,1'b0,1'b1, 32'h100,16'h0, 1'b0,1'b0,16'h0,    1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b0,16'h0, 1'b1,1'b0,16'hA000, 1'b0,1'b1,1'b1,1'b0,1'b1, 32'h102,16'h0, 1'b0,1'b0,16'h0,    1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b0,16'h0, 1'b1,1'b0,16'hA001, 1'b0,1'b1,1'b1,1'b0,1'b1, 32'h104,16'h0, 1'b0,1'b1,16'hA000, 1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b0,16'h0, 1'b1,1'b0,16'hA002, 1'b0,1'b1,1'b1,1'b0,1'b1, 32'h106,16'h0, 1'b0,1'b1,16'hA001, 1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b0,16'h0, 1'b1,1'b0,16'hA003, 1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0,16'h0,   1'b0,1'b1,16'hA002, 1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b0,16'h0, 1'b0,1'b0,16'h0,    1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,16'h0,   1'b0,1'b1,16'hA003, 1'b1,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b0,16'h0, 1'b0,1'b0,16'h0,    1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,16'h0,   1'b0,1'b0,16'h0,    1'b0,1'b0));
        // Write len=1 @0x200, stall held three cycles on beat 0.
        vecs.push_back(V(1'b1,1'b1,32'h200,3'd1, 1'b0,16'h0,    1'b0,1'b0,16'h0, 1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,16'h0,      1'b0,1'b0,16'h0, 1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b1,16'h1111, 1'b0,1'b1,16'h0, 1'b0,1'b1,1'b1,1'b1,1'b1, 32'h200,16'h1111, 1'b0,1'b0,16'h0, 1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b1,16'h1111, 1'b0,1'b1,16'h0, 1'b0,1'b1,1'b1,1'b1,1'b1, 32'h200,16'h1111, 1'b0,1'b0,16'h0, 1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b1,16'h1111, 1'b0,1'b1,16'h0, 1'b0,1'b1,1'b1,1'b1,1'b1, 32'h200,16'h1111, 1'b0,1'b0,16'h0, 1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b1,16'h1111, 1'b0,1'b0,16'h0, 1'b0,1'b1,1'b1,1'b1,1'b1, 32'h200,16'h1111, 1'b1,1'b0,16'h0, 1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b1,16'h2222, 1'b1,1'b0,16'h0, 1'b0,1'b1,1'b1,1'b1,1'b1, 32'h202,16'h2222, 1'b1,1'b0,16'h0, 1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b0,16'h0,    1'b1,1'b0,16'h0, 1'b0,1'b1,1'b0,1'b1,1'b1, 32'h0,16'h0,      1'b0,1'b0,16'h0, 1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b0,16'h0,    1'b0,1'b0,16'h0, 1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,16'h0,      1'b0,1'b0,16'h0, 1'b1,1'b0));
        // Read len=1 across the top of the address space: wraps to 0.
        vecs.push_back(V(1'b1,1'b0,32'hFFFF_FFFE,3'd1, 1'b0,16'h0, 1'b0,1'b0,16'h0,    1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,16'h0,         1'b0,1'b0,16'h0,    1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,         1'b0,16'h0, 1'b0,1'b0,16'h0,    1'b0,1'b1,1'b1,1'b0,1'b1, 32'hFFFF_FFFE,16'h0, 1'b0,1'b0,16'h0,    1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,         1'b0,16'h0, 1'b1,1'b0,16'hB000, 1'b0,1'b1,1'b1,1'b0,1'b1, 32'h0,16'h0,         1'b0,1'b0,16'h0,    1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,         1'b0,16'h0, 1'b1,1'b0,16'hB001, 1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0,16'h0,         1'b0,1'b1,16'hB000, 1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,         1'b0,16'h0, 1'b0,1'b0,16'h0,    1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,16'h0,         1'b0,1'b1,16'hB001, 1'b1,1'b0));
        // Single-beat read: lock stays low.
        vecs.push_back(V(1'b1,1'b0,32'h300,3'd0, 1'b0,16'h0, 1'b0,1'b0,16'h0,    1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,16'h0,   1'b0,1'b0,16'h0,    1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b0,16'h0, 1'b0,1'b0,16'h0,    1'b0,1'b1,1'b1,1'b0,1'b0, 32'h300,16'h0, 1'b0,1'b0,16'h0,    1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b0,16'h0, 1'b1,1'b0,16'hC000, 1'b0,1'b1,1'b0,1'b0,1'b0, 32'h0,16'h0,   1'b0,1'b0,16'h0,    1'b0,1'b0));
        vecs.push_back(V(1'b0,1'b0,32'h0,3'd0,   1'b0,16'h0, 1'b0,1'b0,16'h0,    1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,16'h0,   1'b0,1'b1,16'hC000, 1'b1,1'b0));

        rstN = 1'b0;
        clearInputs();
        #3;
        checkFlag("reset req_ready", reqReady, 1'b0);
        checkFlag("reset cyc", wbIf.cyc, 1'b0);
        checkFlag("reset stb", wbIf.stb, 1'b0);
        checkOutput("reset adr", wbIf.adr, 32'h0);
        checkOutput("reset sel", 32'(wbIf.sel), 32'h0);
        checkFlag("reset done", done, 1'b0);
        checkFlag("reset rd_valid", rdValid, 1'b0);
        nextCycle();
        checkFlag("reset held req_ready", reqReady, 1'b0);
        #6 rstN = 1'b1;
        nextCycle();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkRow(vecs[i], i);
            nextCycle();
        end
        clearInputs();

        // Read len=2 @0x400, rty replaces the second ack; whole burst replays.
        reqValid = 1'b1; reqAddr = 32'h400; reqLen = 3'd2;
        @(negedge clk); checkFlag("rty ready", reqReady, 1'b1);
        nextCycle(); reqValid = 1'b0;
        @(negedge clk); checkOutput("rty adr0", wbIf.adr, 32'h400);
        nextCycle(); setBus(1'b1, 1'b0, 1'b0, 1'b0, 16'hD000);
        @(negedge clk); checkOutput("rty adr1", wbIf.adr, 32'h402);
        nextCycle(); setBus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        @(negedge clk); checkOutput("rty adr2", wbIf.adr, 32'h404);
        checkFlag("rty first rd_valid", rdValid, 1'b1);
        nextCycle(); setBus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk); checkFlag("rty cyc gap", wbIf.cyc, 1'b0); checkFlag("rty no done", done, 1'b0);
        nextCycle();
        @(negedge clk); checkFlag("rty cyc back", wbIf.cyc, 1'b1); checkOutput("rty restart adr", wbIf.adr, 32'h400);
        nextCycle(); setBus(1'b1, 1'b0, 1'b0, 1'b0, 16'hD000);
        @(negedge clk); checkOutput("rty re adr1", wbIf.adr, 32'h402);
        nextCycle(); setBus(1'b1, 1'b0, 1'b0, 1'b0, 16'hD001);
        @(negedge clk); checkOutput("rty redeliver data", 32'(rdData), 32'hD000);
        nextCycle(); setBus(1'b1, 1'b0, 1'b0, 1'b0, 16'hD002);
        @(negedge clk); checkFlag("rty wait stb", wbIf.stb, 1'b0); checkOutput("rty data1", 32'(rdData), 32'hD001);
        nextCycle(); setBus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk); checkFlag("rty done", done, 1'b1); checkFlag("rty err", errO, 1'b0);
        checkOutput("rty data2", 32'(rdData), 32'hD002);
        nextCycle();

        // rty on every attempt: RETRY_LIMIT=3 allows four attempts before failing.
        reqValid = 1'b1; reqAddr = 32'h500; reqLen = 3'd0;
        nextCycle(); reqValid = 1'b0; wbIf.rty = 1'b1;
        attempts = 0; prevCyc = 1'b0; seen = 1'b0; errSeen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                errSeen = errO;
            end else if (wbIf.cyc && !prevCyc) begin
                attempts++;
            end
            prevCyc = wbIf.cyc;
            nextCycle();
        end
        wbIf.rty = 1'b0;
        checkFlag("retry limit done seen", seen, 1'b1);
        checkOutput("retry limit attempts", 32'(attempts), 32'd4);
        checkFlag("retry limit err", errSeen, 1'b1);

        // A write burst fails on its first rty.
        reqValid = 1'b1; reqWe = 1'b1; reqAddr = 32'h700; reqLen = 3'd0;
        nextCycle(); reqValid = 1'b0; wrValid = 1'b1; wrData = 16'h4444; wbIf.rty = 1'b1;
        @(negedge clk); checkFlag("wr rty stb", wbIf.stb, 1'b1);
        nextCycle(); clearInputs();
        @(negedge clk); checkFlag("wr rty done", done, 1'b1); checkFlag("wr rty err", errO, 1'b1);
        checkFlag("wr rty cyc", wbIf.cyc, 1'b0);
        nextCycle();

        // err together with ack on beat 1 of a len=3 write: err wins.
        reqValid = 1'b1; reqWe = 1'b1; reqAddr = 32'h600; reqLen = 3'd3;
        nextCycle(); reqValid = 1'b0; wrValid = 1'b1; wrData = 16'h3000;
        @(negedge clk); checkOutput("err adr0", wbIf.adr, 32'h600);
        nextCycle(); wrData = 16'h3001; setBus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk); checkOutput("err dat1", 32'(wbIf.datW), 32'h3001);
        nextCycle(); wrData = 16'h3002; setBus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        @(negedge clk); checkFlag("err stb", wbIf.stb, 1'b1);
        nextCycle(); clearInputs();
        @(negedge clk); checkFlag("err cyc drop", wbIf.cyc, 1'b0); checkFlag("err done", done, 1'b1);
        checkFlag("err err_o", errO, 1'b1); checkFlag("err ready", reqReady, 1'b1);
        nextCycle();
        @(negedge clk); checkFlag("err done pulse", done, 1'b0);

        // err/rty/ack with cyc low must be ignored.
        nextCycle(); setBus(1'b1, 1'b0, 1'b1, 1'b1, 16'hEEEE);
        nextCycle(); clearInputs();
        @(negedge clk); checkFlag("idle resp done", done, 1'b0); checkFlag("idle resp rd_valid", rdValid, 1'b0);
        nextCycle();

        // Reset in the middle of a read burst.
        reqValid = 1'b1; reqAddr = 32'h800; reqLen = 3'd3;
        nextCycle(); reqValid = 1'b0;
        @(negedge clk); checkFlag("mid pre cyc", wbIf.cyc, 1'b1);
        nextCycle();
        #2 rstN = 1'b0;
        #1;
        checkFlag("mid cyc", wbIf.cyc, 1'b0); checkFlag("mid stb", wbIf.stb, 1'b0);
        checkFlag("mid lock", wbIf.lock, 1'b0); checkFlag("mid ready", reqReady, 1'b0);
        checkOutput("mid adr", wbIf.adr, 32'h0);
        nextCycle();
        checkFlag("mid no done", done, 1'b0);
        #3 rstN = 1'b1;
        nextCycle();
        @(negedge clk); checkFlag("post reset ready", reqReady, 1'b1); checkFlag("post reset cyc", wbIf.cyc, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
